// File: rtl/keypad_scanner.sv
// 4x3 phone-keypad scanner: column drive, row synchronizer, frame capture and
// a press/release debouncer that emits one digit or '#' strobe per physical press.
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [3:0] key,
  output logic       pressed,
  output logic       set_code,
  output logic       held
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0] IDX_STAR = 4'd9;
  localparam logic [3:0] IDX_HASH = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [SW-1:0] r_slot;
  logic [1:0]    r_col;
  logic [2:0]    r_col_n;
  logic [11:0]   r_frame;
  state_t        r_state;
  logic [3:0]    r_cand;
  logic [3:0]    r_cnt;
  logic [3:0]    r_key;
  logic          r_pressed;
  logic          r_set_code;
  logic          r_held;

  logic          w_slot_last;
  logic          w_frame_end;
  logic [1:0]    w_col_next;
  logic [11:0]   w_frame;
  logic [3:0]    w_count;
  logic [3:0]    w_idx;
  logic          w_none;
  logic          w_single;
  state_t        w_state_next;
  logic [3:0]    w_cand_next;
  logic [3:0]    w_cnt_next;
  logic          w_accept;
  logic [3:0]    w_digit;
  logic          w_is_digit;

  assign w_slot_last = (r_slot == SW'(SCAN_DIV - 1));
  assign w_frame_end = w_slot_last && (r_col == 2'd2);
  assign w_col_next  = (r_col == 2'd2) ? 2'd0 : r_col + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
      r_slot  <= '0;
      r_col   <= 2'd0;
      r_col_n <= 3'b110;
    end else begin
      r_sync1 <= row_n;
      r_sync2 <= r_sync1;
      if (w_slot_last) begin
        r_slot  <= '0;
        r_col   <= w_col_next;
        r_col_n <= ~(3'b001 << w_col_next);
      end else begin
        r_slot <= r_slot + SW'(1);
      end
    end
  end

  // Bit row*3+col of the frame image; the last column is merged in on the
  // frame-end edge itself so classification sees a complete frame.
  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_frame
      localparam int ROW = gi / 3;
      localparam int COL = gi % 3;
      assign w_frame[gi] = (w_slot_last && (r_col == 2'(COL))) ? ~r_sync2[ROW] : r_frame[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame <= '0;
    else        r_frame <= w_frame;
  end

  always_comb begin
    w_count = 4'd0;
    w_idx   = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (w_frame[i]) begin
        w_count = w_count + 4'd1;
        w_idx   = 4'(i);
      end
    end
  end

  assign w_none   = (w_count == 4'd0);
  assign w_single = (w_count == 4'd1);

  always_comb begin
    w_state_next = r_state;
    w_cand_next  = r_cand;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    if (w_frame_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_cand_next = w_idx;
            if (DEBOUNCE == 1) begin
              w_accept     = 1'b1;
              w_state_next = S_HELD;
            end else begin
              w_cnt_next   = 4'd1;
              w_state_next = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (w_single && (w_idx == r_cand)) begin
            w_cnt_next = r_cnt + 4'd1;
            if (r_cnt + 4'd1 == 4'(DEBOUNCE)) begin
              w_accept     = 1'b1;
              w_state_next = S_HELD;
            end
          end else begin
            w_state_next = S_IDLE;
          end
        end
        S_HELD: begin
          if (w_none) begin
            if (DEBOUNCE == 1) begin
              w_state_next = S_IDLE;
            end else begin
              w_cnt_next   = 4'd1;
              w_state_next = S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          if (w_none) begin
            w_cnt_next = r_cnt + 4'd1;
            if (r_cnt + 4'd1 == 4'(DEBOUNCE)) w_state_next = S_IDLE;
          end else begin
            w_state_next = S_HELD;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Position index to digit; '*' and '#' are not digits.
  always_comb begin
    w_digit    = 4'd0;
    w_is_digit = 1'b1;
    if (w_cand_next <= 4'd8)          w_digit = w_cand_next + 4'd1;
    else if (w_cand_next == 4'd10)    w_digit = 4'd0;
    else                              w_is_digit = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cand     <= 4'd0;
      r_cnt      <= 4'd0;
      r_key      <= 4'd0;
      r_pressed  <= 1'b0;
      r_set_code <= 1'b0;
      r_held     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cand     <= w_cand_next;
      r_cnt      <= w_cnt_next;
      r_pressed  <= w_accept && w_is_digit;
      r_set_code <= w_accept && (w_cand_next == IDX_HASH);
      r_held     <= (w_state_next == S_HELD) || (w_state_next == S_RELEASE);
      if (w_accept && w_is_digit && (w_cand_next != IDX_STAR)) r_key <= w_digit;
    end
  end

  assign col_n    = r_col_n;
  assign key      = r_key;
  assign pressed  = r_pressed;
  assign set_code = r_set_code;
  assign held     = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: combinational matrix model, frame-level reference
// model compared every cycle, directed scenarios pinned by literal expectations.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int FRAME    = 3 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [3:0] key;
  logic       pressed;
  logic       set_code;
  logic       held;

  logic [11:0] keys_down = '0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_n    (row_n),
    .col_n    (col_n),
    .key      (key),
    .pressed  (pressed),
    .set_code (set_code),
    .held     (held)
  );

  // Matrix: a row is pulled low when its key sits in a driven column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!col_n[c] && keys_down[r*3+c]) row_n[r] = 1'b0;
  end

  // Reference model state (frame-level abstraction).
  int         tcyc = 0;
  int         ncyc = 0;
  bit         m_down;
  int         m_cand;
  int         m_streak;
  int         m_rel;
  logic       exp_p;
  logic       exp_s;
  logic       exp_h;
  logic [3:0] exp_key;
  int         digit_of [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -1, 0, -2};

  typedef struct {
    int         cyc;
    logic       p;
    logic       s;
    logic       h;
    logic [3:0] k;
    logic [2:0] col;
  } lit_t;
  lit_t lit_q[$];

  int vectors = 0;
  int miscompares = 0;
  bit done = 0;
  bit cmp_done = 0;

  task automatic model_reset();
    ncyc = 0; m_down = 0; m_cand = 0; m_streak = 0; m_rel = 0;
    exp_p = 0; exp_s = 0; exp_h = 0; exp_key = 4'd0;
  endtask

  task automatic emit(input int c);
    if (digit_of[c] >= 0) begin
      exp_p = 1'b1;
      exp_key = 4'(digit_of[c]);
    end else if (digit_of[c] == -2) begin
      exp_s = 1'b1;
    end
  endtask

  task automatic frame_update();
    int nk;
    int k;
    nk = $countones(keys_down);
    k = 0;
    for (int i = 0; i < 12; i++) if (keys_down[i]) k = i;
    if (!m_down) begin
      if (nk == 1 && (m_streak == 0 || k == m_cand)) begin
        if (m_streak == 0) m_cand = k;
        m_streak++;
        if (m_streak >= DEB) begin
          m_down = 1; m_streak = 0; m_rel = 0;
          emit(m_cand);
        end
      end else begin
        m_streak = 0;
      end
    end else if (nk == 0) begin
      m_rel++;
      if (m_rel >= DEB) begin m_down = 0; m_rel = 0; end
    end else begin
      m_rel = 0;
    end
    exp_h = m_down;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tcyc++;
    if (rst_n) begin
      ncyc++;
      exp_p = 1'b0;
      exp_s = 1'b0;
      if (ncyc % FRAME == 0) frame_update();
    end
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) tick();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    #1 rst_n = 1'b1;
  endtask

  task automatic push_lit(input int cyc, input logic p, input logic s, input logic h,
                          input logic [3:0] k, input logic [2:0] col);
    lit_t l;
    l.cyc = cyc; l.p = p; l.s = s; l.h = h; l.k = k; l.col = col;
    lit_q.push_back(l);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, tcyc, act, exp);
    end
  endtask

  // Compare process: model every cycle, plus literal pins at chosen cycles.
  initial begin
    logic [2:0] exp_col;
    lit_t l;
    while (!done) begin
      @(negedge clk);
      exp_col = ~(3'b001 << ((ncyc / SCAN_DIV) % 3));
      chk("pressed",  {3'b0, pressed},  {3'b0, exp_p});
      chk("set_code", {3'b0, set_code}, {3'b0, exp_s});
      chk("held",     {3'b0, held},     {3'b0, exp_h});
      chk("key",      key,              exp_key);
      chk("col_n",    {1'b0, col_n},    {1'b0, exp_col});
      if (pressed || set_code)
        $display("cycle %0d: strobe pressed=%0b set_code=%0b key=%0d", tcyc, pressed, set_code, key);
      while (lit_q.size() > 0 && lit_q[0].cyc <= tcyc) begin
        l = lit_q.pop_front();
        if (l.cyc < tcyc) begin
          vectors++;
          miscompares++;
          $display("FAIL lit_missed: cycle %0d passed, now %0d", l.cyc, tcyc);
        end else begin
          chk("lit_pressed",  {3'b0, pressed},  {3'b0, l.p});
          chk("lit_set_code", {3'b0, set_code}, {3'b0, l.s});
          chk("lit_held",     {3'b0, held},     {3'b0, l.h});
          chk("lit_key",      key,              l.k);
          chk("lit_col_n",    {1'b0, col_n},    {1'b0, l.col});
        end
      end
    end
    vectors++;
    if (lit_q.size() != 0) begin
      miscompares++;
      $display("FAIL lit_left: got %0d unchecked, expected 0", lit_q.size());
    end
    cmp_done = 1;
  end

  initial begin
    int base;
    int r;
    int i1;
    int i2;
    model_reset();

    // 1: '5' held from reset release
    keys_down = 12'b1 << 4;
    apply_reset();
    base = tcyc;
    $display("test 1: hold 5 from reset");
    push_lit(base,      0, 0, 0, 4'd0, 3'b110);
    push_lit(base + 35, 0, 0, 0, 4'd0, 3'b011);
    push_lit(base + 36, 1, 0, 1, 4'd5, 3'b110);
    push_lit(base + 37, 0, 0, 1, 4'd5, 3'b110);
    frames(17);
    keys_down = '0;
    frames(4);

    // 2: bounce on '7'
    $display("test 2: bounce then hold 7");
    base = tcyc;
    push_lit(base + 59, 0, 0, 0, 4'd5, 3'b011);
    push_lit(base + 60, 1, 0, 1, 4'd7, 3'b110);
    keys_down = 12'b1 << 6; frames(1);
    keys_down = '0;         frames(1);
    keys_down = 12'b1 << 6; frames(5);
    keys_down = '0;         frames(4);

    // 3: '#' then '*'
    $display("test 3: hash and star");
    base = tcyc;
    push_lit(base + 36, 0, 1, 1, 4'd7, 3'b110);
    keys_down = 12'b1 << 11; frames(5);
    keys_down = '0;          frames(4);
    base = tcyc;
    push_lit(base + 36, 0, 0, 1, 4'd7, 3'b110);
    push_lit(base + 60, 0, 0, 1, 4'd7, 3'b110);
    keys_down = 12'b1 << 9; frames(5);
    keys_down = '0;         frames(4);

    // 4: '1'+'2' together, then '1' alone
    $display("test 4: multi-key then single");
    base = tcyc;
    push_lit(base + 119, 0, 0, 0, 4'd7, 3'b011);
    keys_down = 12'b11; frames(10);
    base = tcyc;
    push_lit(base + 36, 1, 0, 1, 4'd1, 3'b110);
    keys_down = 12'b1; frames(5);
    keys_down = '0;    frames(4);

    // 5: '4' with short and long releases
    $display("test 5: release debounce on 4");
    base = tcyc;
    push_lit(base + 36,  1, 0, 1, 4'd4, 3'b110);
    push_lit(base + 84,  0, 0, 1, 4'd4, 3'b110);
    push_lit(base + 120, 0, 0, 1, 4'd4, 3'b110);
    keys_down = 12'b1 << 3; frames(4);
    keys_down = '0;         frames(2);
    keys_down = 12'b1 << 3; frames(4);
    keys_down = '0;         frames(4);
    base = tcyc;
    push_lit(base + 36,  1, 0, 1, 4'd4, 3'b110);
    push_lit(base + 84,  0, 0, 0, 4'd4, 3'b110);
    push_lit(base + 120, 1, 0, 1, 4'd4, 3'b110);
    keys_down = 12'b1 << 3; frames(4);
    keys_down = '0;         frames(3);
    keys_down = 12'b1 << 3; frames(4);
    keys_down = '0;         frames(4);

    // 6: reset during debounce of '9'
    $display("test 6: reset mid-debounce on 9");
    keys_down = 12'b1 << 8;
    frames(2);
    repeat (5) tick();
    keys_down = '0;
    push_lit(tcyc, 0, 0, 0, 4'd0, 3'b110);
    apply_reset();
    base = tcyc;
    push_lit(base,       0, 0, 0, 4'd0, 3'b110);
    push_lit(base + 100, 0, 0, 0, 4'd0, 3'b101);
    frames(9);

    // Random frames against the model
    $display("random phase");
    for (int f = 0; f < 300; f++) begin
      r = $urandom_range(0, 9);
      if (r >= 4 && r <= 5) begin
        keys_down = '0;
      end else if (r >= 6 && r <= 8) begin
        keys_down = 12'b1 << $urandom_range(0, 11);
      end else if (r == 9) begin
        i1 = $urandom_range(0, 11);
        i2 = (i1 + 1 + $urandom_range(0, 10)) % 12;
        keys_down = (12'b1 << i1) | (12'b1 << i2);
      end
      frames(1);
    end
    keys_down = '0;
    frames(4);

    done = 1;
    wait (cmp_done);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
